// File: rtl/navic_tiered_pkg.sv
// Shared types and constants for the NavIC tiered spreading-code generator.
package navic_tiered_pkg;

  // Control states: PEND is a running state holding a shadow init set
  // that is waiting for the next secondary epoch.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  // Width of the code-phase slew request.
  localparam int SLEW_W = 16;

  // Fill bit for the default init words; the generators start from all-ones.
  localparam logic INIT_FILL_BIT = 1'b1;

endpackage

// File: rtl/tiered_lfsr.sv
// Fibonacci LFSR with a parallel init load. The output chip is q[0].
module tiered_lfsr #(
  parameter int             W       = 10,
  parameter logic [W-1:0]   TAPS    = '0,
  parameter logic [W-1:0]   RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         adv,
  input  logic [W-1:0] init,
  output logic [W-1:0] q
);

  // Load wins over advance so a wrap chip starts cleanly from the init value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= RST_VAL;
    else if (load) q <= init;
    else if (adv)  q <= {^(q & TAPS), q[W-1:1]};
  end

endmodule

// File: rtl/navic_tiered_code_gen.sv
// Tiered spreading-code generator: primary = XOR of two short-cycled LFSRs,
// secondary = one short-cycled LFSR stepped once per primary epoch.
// Chip timing comes from an NCO carry, optionally topped up by a slew count.
module navic_tiered_code_gen
  import navic_tiered_pkg::*;
#(
  parameter int               PRI_W         = 10,
  parameter logic [PRI_W-1:0] PRI_TAPS0     = 10'h009,
  parameter logic [PRI_W-1:0] PRI_TAPS1     = 10'h3A6,
  parameter int               PRI_LEN       = 1023,
  parameter int               SEC_W         = 5,
  parameter logic [SEC_W-1:0] SEC_TAPS      = 5'h05,
  parameter int               SEC_LEN       = 20,
  parameter int               NCO_W         = 32,
  parameter logic [PRI_W-1:0] PRI_INIT0_DEF = {PRI_W{INIT_FILL_BIT}},
  parameter logic [PRI_W-1:0] PRI_INIT1_DEF = {PRI_W{INIT_FILL_BIT}},
  parameter logic [SEC_W-1:0] SEC_INIT_DEF  = {SEC_W{INIT_FILL_BIT}}
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        stop,
  input  logic [NCO_W-1:0]            nco_fcw,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [PRI_W-1:0]            cfg_pri0,
  input  logic [PRI_W-1:0]            cfg_pri1,
  input  logic [SEC_W-1:0]            cfg_sec,
  input  logic                        slew_valid,
  output logic                        slew_ready,
  input  logic [SLEW_W-1:0]           slew_chips,
  output logic                        chip_out,
  output logic                        pri_chip,
  output logic                        sec_chip,
  output logic                        chip_stb,
  output logic                        pri_epoch,
  output logic                        sec_epoch,
  output logic [$clog2(PRI_LEN)-1:0]  chip_idx,
  output logic [$clog2(SEC_LEN)-1:0]  sec_idx,
  output logic                        running
);

  localparam int CI_W = $clog2(PRI_LEN);
  localparam int SI_W = $clog2(SEC_LEN);
  localparam logic [CI_W-1:0] PRI_LAST = CI_W'(PRI_LEN - 1);
  localparam logic [SI_W-1:0] SEC_LAST = SI_W'(SEC_LEN - 1);

  state_t              state;
  logic [NCO_W-1:0]    acc;
  logic [SLEW_W-1:0]   slew_cnt;
  logic [PRI_W-1:0]    act_p0, act_p1, sh_p0, sh_p1;
  logic [SEC_W-1:0]    act_s, sh_s;
  logic [PRI_W-1:0]    r0, r1, ld_p0, ld_p1;
  logic [SEC_W-1:0]    rs, ld_s;
  logic [NCO_W:0]      nco_sum;
  logic                active, carry, go, adv, pri_wrap, sec_wrap, apply_sh;
  logic                cfg_fire, slew_fire;

  // PEND counts as running: the code keeps flowing while the shadow waits.
  assign active     = (state != IDLE);
  assign running    = active;
  assign cfg_ready  = (state != PEND);
  assign slew_ready = active & (slew_cnt == '0);
  assign cfg_fire   = cfg_valid & cfg_ready;
  assign slew_fire  = slew_valid & slew_ready;

  assign nco_sum  = {1'b0, acc} + {1'b0, nco_fcw};
  assign carry    = active & nco_sum[NCO_W];
  // The stop cycle never advances, so indices hold exactly where they were.
  assign go       = (state == IDLE) & start & ~stop;
  assign adv      = active & ~stop & (carry | (slew_cnt != '0));
  assign pri_wrap = adv & (chip_idx == PRI_LAST);
  assign sec_wrap = pri_wrap & (sec_idx == SEC_LAST);
  assign apply_sh = sec_wrap & (state == PEND);

  // Init source: a start in the same cycle as an IDLE config load sees the new
  // words; a pending shadow replaces the active set at the secondary wrap.
  always_comb begin
    ld_p0 = act_p0;
    ld_p1 = act_p1;
    ld_s  = act_s;
    if (go && cfg_fire) begin
      ld_p0 = cfg_pri0;
      ld_p1 = cfg_pri1;
      ld_s  = cfg_sec;
    end else if (apply_sh) begin
      ld_p0 = sh_p0;
      ld_p1 = sh_p1;
      ld_s  = sh_s;
    end
  end

  tiered_lfsr #(.W(PRI_W), .TAPS(PRI_TAPS0), .RST_VAL(PRI_INIT0_DEF)) u_pri0 (
    .clk(clk), .rst_n(rst_n), .load(go | pri_wrap), .adv(adv), .init(ld_p0), .q(r0));
  tiered_lfsr #(.W(PRI_W), .TAPS(PRI_TAPS1), .RST_VAL(PRI_INIT1_DEF)) u_pri1 (
    .clk(clk), .rst_n(rst_n), .load(go | pri_wrap), .adv(adv), .init(ld_p1), .q(r1));
  tiered_lfsr #(.W(SEC_W), .TAPS(SEC_TAPS), .RST_VAL(SEC_INIT_DEF)) u_sec (
    .clk(clk), .rst_n(rst_n), .load(go | sec_wrap), .adv(pri_wrap), .init(ld_s), .q(rs));

  assign pri_chip = r0[0] ^ r1[0];
  assign sec_chip = rs[0];
  assign chip_out = pri_chip ^ sec_chip;

  // Control FSM plus active/shadow init registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      act_p0 <= PRI_INIT0_DEF;
      act_p1 <= PRI_INIT1_DEF;
      act_s  <= SEC_INIT_DEF;
      sh_p0  <= PRI_INIT0_DEF;
      sh_p1  <= PRI_INIT1_DEF;
      sh_s   <= SEC_INIT_DEF;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_fire) begin
            act_p0 <= cfg_pri0;
            act_p1 <= cfg_pri1;
            act_s  <= cfg_sec;
          end
          if (go) state <= RUN;
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            if (cfg_fire) begin
              act_p0 <= cfg_pri0;
              act_p1 <= cfg_pri1;
              act_s  <= cfg_sec;
            end
          end else if (cfg_fire) begin
            sh_p0 <= cfg_pri0;
            sh_p1 <= cfg_pri1;
            sh_s  <= cfg_sec;
            state <= PEND;
          end
        end
        PEND: begin
          if (stop || sec_wrap) begin
            act_p0 <= sh_p0;
            act_p1 <= sh_p1;
            act_s  <= sh_s;
            state  <= stop ? IDLE : RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Chip-rate NCO and slew counter; a carry cycle never consumes a slew chip.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      slew_cnt <= '0;
    end else if (go || (active && stop)) begin
      acc      <= '0;
      slew_cnt <= '0;
    end else if (active) begin
      acc <= nco_sum[NCO_W-1:0];
      if (slew_fire)                       slew_cnt <= slew_chips;
      else if (slew_cnt != '0 && !carry)   slew_cnt <= slew_cnt - 1'b1;
    end
  end

  // Chip/secondary indices and the registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chip_idx  <= '0;
      sec_idx   <= '0;
      chip_stb  <= 1'b0;
      pri_epoch <= 1'b0;
      sec_epoch <= 1'b0;
    end else begin
      chip_stb  <= adv;
      pri_epoch <= pri_wrap;
      sec_epoch <= sec_wrap;
      if (go) begin
        chip_idx <= '0;
        sec_idx  <= '0;
      end else if (adv) begin
        chip_idx <= pri_wrap ? '0 : chip_idx + 1'b1;
        if (pri_wrap) sec_idx <= sec_wrap ? '0 : sec_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_navic_tiered_code_gen.sv
// Directed bench for navic_tiered_code_gen with PRI_LEN=7, SEC_LEN=3
// (21-chip full code period). Expected chips come from a small LFSR model.
module tb_navic_tiered_code_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0;
  logic [31:0] nco_fcw = '0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [9:0]  cfg_pri0 = '0, cfg_pri1 = '0;
  logic [4:0]  cfg_sec = '0;
  logic        slew_valid = 1'b0;
  logic        slew_ready;
  logic [15:0] slew_chips = '0;
  logic        chip_out, pri_chip, sec_chip, chip_stb, pri_epoch, sec_epoch, running;
  logic [2:0]  chip_idx;
  logic [1:0]  sec_idx;

  int tests = 0;
  int fails = 0;

  logic [6:0] p_a, p_b, p_d;
  logic [2:0] s_a, s_b, s_d;
  logic [10:0] obs, e;

  localparam logic [9:0] A0 = 10'h155, A1 = 10'h0A3;
  localparam logic [4:0] AS = 5'h12;
  localparam logic [9:0] B0 = 10'h2C9, B1 = 10'h31E;
  localparam logic [4:0] BS = 5'h0B;
  localparam logic [31:0] HALF = 32'h8000_0000;

  navic_tiered_code_gen #(.PRI_LEN(7), .SEC_LEN(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .nco_fcw(nco_fcw),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pri0(cfg_pri0),
    .cfg_pri1(cfg_pri1), .cfg_sec(cfg_sec), .slew_valid(slew_valid),
    .slew_ready(slew_ready), .slew_chips(slew_chips), .chip_out(chip_out),
    .pri_chip(pri_chip), .sec_chip(sec_chip), .chip_stb(chip_stb),
    .pri_epoch(pri_epoch), .sec_epoch(sec_epoch), .chip_idx(chip_idx),
    .sec_idx(sec_idx), .running(running));

  always #5 clk = ~clk;

  assign obs = {chip_stb, pri_epoch, sec_epoch, chip_out, pri_chip, sec_chip, chip_idx, sec_idx};

  // Chip sequences of one primary epoch and one secondary epoch from a given init.
  task automatic build(input logic [9:0] p0, input logic [9:0] p1, input logic [4:0] s,
                       output logic [6:0] pv, output logic [2:0] sv);
    logic [9:0] a, b;
    logic [4:0] c;
    a = p0; b = p1; c = s;
    for (int k = 0; k < 7; k++) begin
      pv[k] = a[0] ^ b[0];
      a = {^(a & 10'h009), a[9:1]};
      b = {^(b & 10'h3A6), b[9:1]};
    end
    for (int k = 0; k < 3; k++) begin
      sv[k] = c[0];
      c = {^(c & 5'h05), c[4:1]};
    end
  endtask

  // Expected observation vector for global chip number n since start.
  function automatic logic [10:0] exp_vec(input logic [6:0] pv, input logic [2:0] sv,
                                          input int n, input logic stb);
    logic p, s;
    p = pv[n % 7];
    s = sv[(n / 7) % 3];
    return {stb, stb && (n % 7 == 0), stb && (n % 21 == 0), p ^ s, p, s,
            3'(n % 7), 2'((n / 7) % 3)};
  endfunction

  task automatic go_idle();
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    e = exp_vec(p_d, s_d, 0, 1'b0);
    tests++;
    if (obs !== e || running !== 1'b0 || cfg_ready !== 1'b1 || slew_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_state obs=%b exp=%b run=%b cfg_rdy=%b slew_rdy=%b", obs, e, running, cfg_ready, slew_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (obs !== e || running !== 1'b0) begin
      fails++;
      $display("FAIL reset_release obs=%b exp=%b run=%b", obs, e, running);
    end
  endtask

  task automatic test_idle_controls();
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    tests++;
    if (running !== 1'b0 || cfg_ready !== 1'b1) begin
      fails++; $display("FAIL stop_in_idle run=%b cfg_rdy=%b exp run=0 rdy=1", running, cfg_ready);
    end
    start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    tests++;
    if (running !== 1'b0 || chip_stb !== 1'b0) begin
      fails++; $display("FAIL start_stop_idle run=%b stb=%b exp 0/0", running, chip_stb);
    end
  endtask

  // IDLE config load in the start cycle, then run three full code periods.
  task automatic test_run_sequence();
    int n;
    logic stb;
    nco_fcw = HALF;
    cfg_valid = 1'b1; cfg_pri0 = A0; cfg_pri1 = A1; cfg_sec = AS; start = 1'b1;
    @(negedge clk); cfg_valid = 1'b0; start = 1'b0;
    for (int c = 1; c <= 90; c++) begin
      if (c > 1) @(negedge clk);
      start = 1'b0;
      n   = (c >= 3) ? (c - 1) / 2 : 0;
      stb = (c >= 3) && (c % 2 == 1);
      e = exp_vec(p_a, s_a, n, stb);
      tests++;
      if (obs !== e || running !== 1'b1) begin
        fails++; $display("FAIL run_seq c=%0d obs=%b exp=%b run=%b", c, obs, e, running);
      end
      if (c == 20) start = 1'b1;   // start while running must be ignored
    end
  endtask

  // Config in RUN at sec_idx=1; new inits take effect at the next secondary wrap.
  task automatic test_cfg_midrun();
    int n;
    logic stb;
    go_idle();
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      if (c > 1) @(negedge clk);
      cfg_valid = 1'b0;
      n   = (c >= 3) ? (c - 1) / 2 : 0;
      stb = (c >= 3) && (c % 2 == 1);
      e = (n >= 21) ? exp_vec(p_b, s_b, n, stb) : exp_vec(p_a, s_a, n, stb);
      tests++;
      if (obs !== e || cfg_ready !== !(c >= 17 && c < 43)) begin
        fails++; $display("FAIL cfg_midrun c=%0d obs=%b exp=%b cfg_rdy=%b", c, obs, e, cfg_ready);
      end
      if (c == 16) begin
        cfg_valid = 1'b1; cfg_pri0 = B0; cfg_pri1 = B1; cfg_sec = BS;
      end
    end
  endtask

  // Stop while PEND: shadow becomes active, next start uses it from chip 0.
  task automatic test_stop_in_pend();
    int n;
    logic stb;
    go_idle();
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) @(negedge clk);
      cfg_valid = 1'b0;
      n   = (c >= 3) ? 1 : 0;
      stb = (c == 3);
      e = exp_vec(p_b, s_b, n, stb);
      tests++;
      if (obs !== e || cfg_ready !== (c < 3)) begin
        fails++; $display("FAIL pend_entry c=%0d obs=%b exp=%b cfg_rdy=%b", c, obs, e, cfg_ready);
      end
      if (c == 2) begin
        cfg_valid = 1'b1; cfg_pri0 = A0; cfg_pri1 = A1; cfg_sec = AS;
      end
    end
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    e = exp_vec(p_b, s_b, 1, 1'b0);
    tests++;
    if (obs !== e || running !== 1'b0 || cfg_ready !== 1'b1) begin
      fails++; $display("FAIL stop_hold obs=%b exp=%b run=%b cfg_rdy=%b", obs, e, running, cfg_ready);
    end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (c > 1) @(negedge clk);
      n   = (c >= 3) ? (c - 1) / 2 : 0;
      stb = (c >= 3) && (c % 2 == 1);
      e = exp_vec(p_a, s_a, n, stb);
      tests++;
      if (obs !== e) begin
        fails++; $display("FAIL shadow_to_active c=%0d obs=%b exp=%b", c, obs, e);
      end
    end
  endtask

  // fcw=0: zero-length slew is a no-op, two slews of 5 (second crosses a wrap).
  task automatic test_slew_fcw0();
    int n;
    logic stb, rdy;
    go_idle();
    nco_fcw = '0;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) @(negedge clk);
      slew_valid = 1'b0;
      n   = ((c - 5 < 0) ? 0 : (c - 5 > 5) ? 5 : c - 5)
          + ((c - 13 < 0) ? 0 : (c - 13 > 5) ? 5 : c - 13);
      stb = (c >= 6 && c <= 10) || (c >= 14 && c <= 18);
      rdy = !((c >= 5 && c <= 9) || (c >= 13 && c <= 17));
      e = exp_vec(p_a, s_a, n, stb);
      tests++;
      if (obs !== e || slew_ready !== rdy) begin
        fails++; $display("FAIL slew_fcw0 c=%0d obs=%b exp=%b slew_rdy=%b exp_rdy=%b", c, obs, e, slew_ready, rdy);
      end
      if (c == 2)  begin slew_valid = 1'b1; slew_chips = 16'd0; end
      if (c == 4)  begin slew_valid = 1'b1; slew_chips = 16'd5; end
      if (c == 12) begin slew_valid = 1'b1; slew_chips = 16'd5; end
    end
  endtask

  // fcw=2^31 with slew 5: carries and slew chips interleave, net +5 chips.
  task automatic test_slew_carry();
    int n;
    logic stb, rdy;
    go_idle();
    nco_fcw = HALF;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk);
      slew_valid = 1'b0;
      if (c < 3)        n = 0;
      else if (c <= 13) n = c - 2;
      else              n = 11 + (c - 13) / 2;
      stb = (c >= 3 && c <= 13) || (c > 13 && c % 2 == 1);
      rdy = (c == 1) || (c >= 12);
      e = exp_vec(p_a, s_a, n, stb);
      tests++;
      if (obs !== e || slew_ready !== rdy) begin
        fails++; $display("FAIL slew_carry c=%0d obs=%b exp=%b slew_rdy=%b exp_rdy=%b", c, obs, e, slew_ready, rdy);
      end
      if (c == 1) begin slew_valid = 1'b1; slew_chips = 16'd5; end
    end
  endtask

  // Async reset in PEND: immediate reset outputs, shadow and active inits lost.
  task automatic test_reset_in_pend();
    int n;
    logic stb;
    go_idle();
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) @(negedge clk);
      cfg_valid = 1'b0;
      if (c == 2) begin
        cfg_valid = 1'b1; cfg_pri0 = B0; cfg_pri1 = B1; cfg_sec = BS;
      end
    end
    tests++;
    if (cfg_ready !== 1'b0 || running !== 1'b1) begin
      fails++; $display("FAIL pend_before_reset cfg_rdy=%b run=%b exp 0/1", cfg_ready, running);
    end
    rst_n = 1'b0;
    #1;
    e = exp_vec(p_d, s_d, 0, 1'b0);
    tests++;
    if (obs !== e || running !== 1'b0 || cfg_ready !== 1'b1 || slew_ready !== 1'b0) begin
      fails++; $display("FAIL async_reset obs=%b exp=%b run=%b cfg_rdy=%b slew_rdy=%b", obs, e, running, cfg_ready, slew_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      if (c > 1) @(negedge clk);
      n   = (c >= 3) ? (c - 1) / 2 : 0;
      stb = (c >= 3) && (c % 2 == 1);
      e = exp_vec(p_d, s_d, n, stb);
      tests++;
      if (obs !== e || cfg_ready !== 1'b1) begin
        fails++; $display("FAIL after_reset c=%0d obs=%b exp=%b cfg_rdy=%b", c, obs, e, cfg_ready);
      end
    end
  endtask

  initial begin
    build(A0, A1, AS, p_a, s_a);
    build(B0, B1, BS, p_b, s_b);
    build(10'h3FF, 10'h3FF, 5'h1F, p_d, s_d);
    test_reset();
    test_idle_controls();
    test_run_sequence();
    test_cfg_midrun();
    test_stop_in_pend();
    test_slew_fcw0();
    test_slew_carry();
    test_reset_in_pend();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
